idli_slice_gather: RTL and testbench

// Receive side of the core's 4b slice stream: collects four consecutive slice_t

---
 rtl/idli_pkg.sv | 35 +++
 rtl/idli_word_fifo.sv | 131 +++++++++++++
 rtl/idli_slice_gather.sv | 135 +++++++++++++
 tb/tb_idli_slice_gather.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli serial core: 4b slices, 16b words, slice phase
// counter, and the gather-side state encoding.
package idli_pkg;

    localparam int unsigned SLICE_W         = 4;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned CTR_W           = 2;
    localparam int unsigned SLICES_PER_WORD = 4;

    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [CTR_W-1:0]   ctr_t;

    typedef enum logic {
        GATHER_IDLE    = 1'b0,
        GATHER_COLLECT = 1'b1
    } gather_state_t;

    localparam ctr_t  CTR_FIRST = 2'd0;
    localparam ctr_t  CTR_ONE   = 2'd1;
    localparam ctr_t  CTR_LAST  = 2'(SLICES_PER_WORD - 1);
    localparam data_t DATA_ZERO = 16'h0000;

    // Return word with the slice at phase pos replaced by s.
    function automatic data_t insert_slice(input data_t word, input ctr_t pos,
                                           input slice_t s);
        data_t       r;
        int unsigned lsb;
        r   = word;
        lsb = int'(pos) * SLICE_W;
        r[lsb +: SLICE_W] = s;
        return r;
    endfunction

endpackage

// File: rtl/idli_word_fifo.sv
// Small FIFO of completed words. The head is held in a register so the
// consumer sees a clean output; o_full also counts a slot reserved for a
// word that is still being assembled upstream.
module idli_word_fifo
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_push,
    input  data_t i_wdata,
    input  logic  i_pop,
    input  logic  i_reserve,
    output logic  o_full,
    output logic  o_vld,
    output data_t o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);

    // Advance a pointer, wrapping modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    data_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OCC_W-1:0] occ_d;
    data_t            head_q, head_d;
    logic             vld_q, full_q, full_d;
    logic             push_s, pop_s;

    // Next-state of pointers, occupancy, registered head and full flag.
    always_comb begin
        pop_s    = i_pop && (count_q != CNT_ZERO);
        push_s   = i_push && ((count_q != CNT_DEPTH) || pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // An incoming word becomes head when nothing older will remain.
        if (count_d == CNT_ZERO) begin
            head_d = DATA_ZERO;
        end else if (push_s && ((count_q == CNT_ZERO) ||
                                (pop_s && (count_q == CNT_ONE)))) begin
            head_d = i_wdata;
        end else if (pop_s) begin
            head_d = mem_q[rd_ptr_d];
        end else begin
            head_d = head_q;
        end

        occ_d  = OCC_W'(count_d) + OCC_W'(i_reserve);
        full_d = (occ_d >= OCC_DEPTH);
    end

    // Storage array: written on push, cleared on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= DATA_ZERO;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end else begin
            mem_q <= mem_q;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            head_q   <= DATA_ZERO;
            vld_q    <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            vld_q    <= (count_d != CNT_ZERO);
            full_q   <= full_d;
        end
    end

    assign o_full = full_q;
    assign o_vld  = vld_q;
    assign o_head = head_q;

endmodule

// File: rtl/idli_slice_gather.sv
// Receive side of the slice stream: assembles four phase-tagged 4b slices
// into a 16b word and queues finished words for a valid/ready consumer.
// A FIFO slot is reserved when a word starts, so the final beat always has
// room to land.
module idli_slice_gather
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_slice_vld,
    input  logic [3:0]  i_slice,
    input  logic [1:0]  i_ctr,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_vld,
    output logic [15:0] o_data,
    input  logic        i_rdy
);

    gather_state_t state_q;
    ctr_t          exp_ctr_q;
    data_t         asm_q;
    logic          err_q;

    logic          busy_s;
    logic          start_s;
    logic          advance_s;
    logic          push_s;
    logic          abort_s;
    logic          reserve_s;
    logic          pop_s;
    logic          fifo_vld_s;
    data_t         fifo_head_s;
    data_t         word_s;

    // Classify this cycle's beat against the gather state.
    always_comb begin
        start_s   = 1'b0;
        advance_s = 1'b0;
        push_s    = 1'b0;
        abort_s   = 1'b0;
        case (state_q)
            GATHER_IDLE: begin
                if (i_slice_vld) begin
                    if (i_ctr == CTR_FIRST) begin
                        // A refused word start is silent: the sender sees o_busy.
                        if (!busy_s) begin
                            start_s = 1'b1;
                        end else begin
                            start_s = 1'b0;
                        end
                    end else begin
                        abort_s = 1'b1;
                    end
                end else begin
                    abort_s = 1'b0;
                end
            end
            GATHER_COLLECT: begin
                if (i_slice_vld && (i_ctr == exp_ctr_q)) begin
                    if (exp_ctr_q == CTR_LAST) begin
                        push_s = 1'b1;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    abort_s = 1'b1;
                    // A mismatched phase-0 beat restarts assembly at once.
                    if (i_slice_vld && (i_ctr == CTR_FIRST) && !busy_s) begin
                        start_s = 1'b1;
                    end else begin
                        start_s = 1'b0;
                    end
                end
            end
            default: begin
                abort_s = 1'b0;
            end
        endcase
        reserve_s = start_s || advance_s;
        word_s    = insert_slice(asm_q, i_ctr, i_slice);
        pop_s     = fifo_vld_s && i_rdy;
    end

    // Gather FSM: state, expected phase, assembly register, error pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= GATHER_IDLE;
            exp_ctr_q <= CTR_FIRST;
            asm_q     <= DATA_ZERO;
            err_q     <= 1'b0;
        end else begin
            err_q <= abort_s;
            if (start_s) begin
                state_q   <= GATHER_COLLECT;
                exp_ctr_q <= CTR_ONE;
                asm_q     <= insert_slice(DATA_ZERO, CTR_FIRST, i_slice);
            end else if (advance_s) begin
                state_q   <= GATHER_COLLECT;
                exp_ctr_q <= exp_ctr_q + CTR_ONE;
                asm_q     <= word_s;
            end else if (push_s || abort_s) begin
                state_q   <= GATHER_IDLE;
                exp_ctr_q <= CTR_FIRST;
                asm_q     <= asm_q;
            end else begin
                state_q   <= state_q;
                exp_ctr_q <= exp_ctr_q;
                asm_q     <= asm_q;
            end
        end
    end

    idli_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (push_s),
        .i_wdata   (word_s),
        .i_pop     (pop_s),
        .i_reserve (reserve_s),
        .o_full    (busy_s),
        .o_vld     (fifo_vld_s),
        .o_head    (fifo_head_s)
    );

    assign o_busy = busy_s;
    assign o_err  = err_q;
    assign o_vld  = fifo_vld_s;
    assign o_data = fifo_head_s;

endmodule

// File: tb/tb_idli_slice_gather.sv
// Directed bench for idli_slice_gather: stimulus pushes expected words into
// a queue, an independent monitor pops and compares on every handshake.
module tb_idli_slice_gather;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_slice_vld;
    logic [3:0]  i_slice;
    logic [1:0]  i_ctr;
    logic        o_busy;
    logic        o_err;
    logic        o_vld;
    logic [15:0] o_data;
    logic        i_rdy;

    int          n_cmp;
    int          n_bad;
    logic [15:0] exp_q[$];

    idli_slice_gather #(.DEPTH(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_slice_vld (i_slice_vld),
        .i_slice     (i_slice),
        .i_ctr       (i_ctr),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_vld       (o_vld),
        .o_data      (o_data),
        .i_rdy       (i_rdy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one cycle of input; returns 1 time unit after the clock edge.
    task automatic beat(input logic v, input logic [1:0] c, input logic [3:0] s);
        i_slice_vld = v;
        i_ctr       = c;
        i_slice     = s;
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard monitor: compares the head on every accepted word.
    always @(negedge i_clk) begin
        if (i_rst_n && o_vld && i_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %h expected no word", o_data);
            end else begin
                check("pop_data", o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        i_rst_n     = 1'b0;
        i_slice_vld = 1'b0;
        i_slice     = 4'h0;
        i_ctr       = 2'd0;
        i_rdy       = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_vld",  {15'd0, o_vld},  16'h0000);
        check("rst_data", o_data,          16'h0000);
        check("rst_busy", {15'd0, o_busy}, 16'h0000);
        check("rst_err",  {15'd0, o_err},  16'h0000);
        i_rst_n = 1'b1;
        beat(1'b0, 2'd0, 4'h0);

        // Basic word, consumer ready: one-cycle valid the cycle after ctr==3.
        beat(1'b1, 2'd0, 4'hA);
        beat(1'b1, 2'd1, 4'hB);
        beat(1'b1, 2'd2, 4'hC);
        exp_q.push_back(16'hDCBA);
        beat(1'b1, 2'd3, 4'hD);
        check("t1_vld_on", {15'd0, o_vld}, 16'h0001);
        beat(1'b0, 2'd0, 4'h0);
        check("t1_vld_off", {15'd0, o_vld}, 16'h0000);

        // Backpressure: two words fill DEPTH=2, third start is refused silently.
        i_rdy = 1'b0;
        beat(1'b1, 2'd0, 4'h5);
        beat(1'b1, 2'd1, 4'h6);
        beat(1'b1, 2'd2, 4'h7);
        exp_q.push_back(16'h8765);
        beat(1'b1, 2'd3, 4'h8);
        check("t2_busy_w1", {15'd0, o_busy}, 16'h0000);
        beat(1'b1, 2'd0, 4'h9);
        check("t2_busy_resv", {15'd0, o_busy}, 16'h0001);
        beat(1'b1, 2'd1, 4'hA);
        beat(1'b1, 2'd2, 4'hB);
        exp_q.push_back(16'hCBA9);
        beat(1'b1, 2'd3, 4'hC);
        check("t2_busy_full", {15'd0, o_busy}, 16'h0001);
        beat(1'b1, 2'd0, 4'hE);
        check("t2_refuse_err", {15'd0, o_err}, 16'h0000);
        check("t2_head_held", o_data, 16'h8765);
        i_rdy = 1'b1;
        beat(1'b0, 2'd0, 4'h0);
        check("t2_busy_drop", {15'd0, o_busy}, 16'h0000);
        beat(1'b0, 2'd0, 4'h0);
        check("t2_empty", {15'd0, o_vld}, 16'h0000);

        // Gap mid-word aborts; next clean word assembles normally.
        beat(1'b1, 2'd0, 4'h7);
        beat(1'b1, 2'd1, 4'h8);
        beat(1'b0, 2'd0, 4'h0);
        check("t3_err_on", {15'd0, o_err}, 16'h0001);
        check("t3_no_vld", {15'd0, o_vld}, 16'h0000);
        beat(1'b0, 2'd0, 4'h0);
        check("t3_err_off", {15'd0, o_err}, 16'h0000);
        beat(1'b1, 2'd0, 4'h1);
        beat(1'b1, 2'd1, 4'h2);
        beat(1'b1, 2'd2, 4'h3);
        exp_q.push_back(16'h4321);
        beat(1'b1, 2'd3, 4'h4);
        beat(1'b0, 2'd0, 4'h0);

        // Phase-0 beat mid-word: error plus restart from that beat.
        beat(1'b1, 2'd0, 4'h1);
        beat(1'b1, 2'd1, 4'h2);
        beat(1'b1, 2'd0, 4'hF);
        check("t4_err_restart", {15'd0, o_err}, 16'h0001);
        beat(1'b1, 2'd1, 4'hE);
        check("t4_err_off", {15'd0, o_err}, 16'h0000);
        beat(1'b1, 2'd2, 4'hD);
        exp_q.push_back(16'hCDEF);
        beat(1'b1, 2'd3, 4'hC);
        beat(1'b0, 2'd0, 4'h0);

        // Stray phase-2 beat in IDLE: error, queued word untouched.
        i_rdy = 1'b0;
        beat(1'b1, 2'd0, 4'h3);
        beat(1'b1, 2'd1, 4'h4);
        beat(1'b1, 2'd2, 4'h5);
        exp_q.push_back(16'h6543);
        beat(1'b1, 2'd3, 4'h6);
        beat(1'b1, 2'd2, 4'h9);
        check("t5_err", {15'd0, o_err}, 16'h0001);
        check("t5_vld", {15'd0, o_vld}, 16'h0001);
        check("t5_head", o_data, 16'h6543);
        beat(1'b0, 2'd0, 4'h0);
        i_rdy = 1'b1;
        beat(1'b0, 2'd0, 4'h0);

        // Asynchronous reset with one word queued and another in flight.
        i_rdy = 1'b0;
        beat(1'b1, 2'd0, 4'h1);
        beat(1'b1, 2'd1, 4'h1);
        beat(1'b1, 2'd2, 4'h2);
        exp_q.push_back(16'h2211);
        beat(1'b1, 2'd3, 4'h2);
        beat(1'b1, 2'd0, 4'h7);
        beat(1'b1, 2'd1, 4'h7);
        beat(1'b1, 2'd2, 4'h7);
        i_slice_vld = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_vld",  {15'd0, o_vld},  16'h0000);
        check("t6_rst_data", o_data,          16'h0000);
        check("t6_rst_busy", {15'd0, o_busy}, 16'h0000);
        check("t6_rst_err",  {15'd0, o_err},  16'h0000);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_rdy   = 1'b1;
        beat(1'b0, 2'd0, 4'h0);
        check("t6_post_err", {15'd0, o_err}, 16'h0000);
        beat(1'b1, 2'd0, 4'hA);
        beat(1'b1, 2'd1, 4'h0);
        beat(1'b1, 2'd2, 4'h5);
        exp_q.push_back(16'hF50A);
        beat(1'b1, 2'd3, 4'hF);
        check("t6_fresh_vld", {15'd0, o_vld}, 16'h0001);
        beat(1'b0, 2'd0, 4'h0);

        // Drain: every expected word must have been observed.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            beat(1'b0, 2'd0, 4'h0);
        end
        check("drain_left", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
